// File: rtl/spi_rx_pkg.sv
// Shared types, default parameter values and sizing helpers for the SPI frame receiver.
package spi_rx_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   localparam int DEFAULT_DATA_WIDTH  = 8;
   localparam int DEFAULT_LINES       = 4;
   localparam int DEFAULT_FIFO_DEPTH  = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Beats per word; the receiver relies on DATA_WIDTH being a multiple of LINES.
   function automatic int beat_count(input int width, input int lines);
      return width / lines;
   endfunction

   // Pointer width with one extra wrap bit to tell full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; a pop frees a slot for a same-cycle write.
module sync_fifo
   import spi_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          valid,
   output logic [ptr_width(DEPTH)-1:0]   fill,
   output logic                          wr_drop
);

   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ADDR_W-1:0] rd_next;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign pop     = rd_en & ~empty;
   assign push    = wr_en & (~full | pop);
   assign wr_drop = wr_en & full & ~pop;
   assign valid   = ~empty;
   assign fill    = wr_ptr - rd_ptr;
   assign rd_next = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
      end
   end

   // The head register holds its last value once the FIFO drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && (empty || (pop && fill == PTR_W'(1)))) begin
            rd_data <= wr_data;
         end else if (pop && fill > PTR_W'(1)) begin
            rd_data <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/spi_frame_receiver.sv
// Multi-lane SPI target receiver: input synchronisers, word assembly, frame/trunc flags and FWFT output FIFO.
// Defining SPI_RX_WORD_COUNT_EN adds word_count_out, counting words accepted into the FIFO.
module spi_frame_receiver
   import spi_rx_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int LINES       = DEFAULT_LINES,
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic [LINES-1:0]                  chip_data_in,
   input  logic                              chip_clk_in,
   input  logic                              chip_sel_in,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              data_valid_out,
   input  logic                              data_ready_in,
   output logic                              frame_end_out,
   output logic                              trunc_out,
   output logic                              overflow_out,
   input  logic                              clear_in,
   output logic [ptr_width(FIFO_DEPTH)-1:0]  fill_out
`ifdef SPI_RX_WORD_COUNT_EN
   ,
   output logic [15:0]                       word_count_out
`endif
);

   localparam int WORD_BEATS = beat_count(DATA_WIDTH, LINES);
   localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
   localparam int LAST       = SYNC_STAGES - 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'((WORD_BEATS - 1) * LINES);
   localparam logic [CNT_W-1:0] BIT_STEP = CNT_W'(LINES);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] scs_sync;
   logic [SYNC_STAGES-1:0] live_sync;
   logic [LINES-1:0]       data_sync [SYNC_STAGES];

   logic                   sclk;
   logic                   scs;
   logic                   live;
   logic                   clk_prev;
   logic                   cs_prev;
   logic                   armed;
   logic                   clk_rise;
   logic                   cs_fall;
   logic                   cs_rise;
   logic [LINES-1:0]       data_smp;

   rx_state_t              state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_WIDTH-1:0]  shift_word;
   logic [DATA_WIDTH-1:0]  shift_in;
   logic                   wr_req;
   logic [DATA_WIDTH-1:0]  wr_word;
   logic                   wr_drop;

   // live_sync marks when the chains hold real pin samples rather than reset values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sclk_sync <= '1;
         scs_sync  <= '1;
         live_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            data_sync[i] <= '0;
         end
      end else begin
         sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], chip_clk_in};
         scs_sync     <= {scs_sync[SYNC_STAGES-2:0], chip_sel_in};
         live_sync    <= {live_sync[SYNC_STAGES-2:0], 1'b1};
         data_sync[0] <= chip_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   assign sclk = sclk_sync[LAST];
   assign scs  = scs_sync[LAST];
   assign live = live_sync[LAST];

   // A cs fall only opens a frame once cs has been seen high, so a frame cut by reset stays ignored.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         clk_prev <= 1'b1;
         cs_prev  <= 1'b1;
         armed    <= 1'b0;
         clk_rise <= 1'b0;
         cs_fall  <= 1'b0;
         cs_rise  <= 1'b0;
         data_smp <= '0;
      end else begin
         clk_prev <= sclk;
         cs_prev  <= scs;
         armed    <= armed | (live & scs);
         clk_rise <= live & sclk & ~clk_prev & ~scs;
         cs_fall  <= live & armed & ~scs & cs_prev;
         cs_rise  <= live & scs & ~cs_prev;
         data_smp <= data_sync[LAST];
      end
   end

   generate
      if (WORD_BEATS == 1) begin : g_single
         assign shift_in = data_smp;
      end else begin : g_multi
         assign shift_in = {shift_word[DATA_WIDTH-LINES-1:0], data_smp};
      end
   endgenerate

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= RX_IDLE;
         bit_cnt       <= '0;
         shift_word    <= '0;
         wr_req        <= 1'b0;
         wr_word       <= '0;
         frame_end_out <= 1'b0;
         trunc_out     <= 1'b0;
      end else begin
         wr_req        <= 1'b0;
         frame_end_out <= 1'b0;
         trunc_out     <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (cs_fall) begin
                  state      <= RX_SHIFT;
                  bit_cnt    <= '0;
                  shift_word <= '0;
               end
            end
            RX_SHIFT: begin
               if (cs_rise) begin
                  state         <= RX_IDLE;
                  frame_end_out <= 1'b1;
                  trunc_out     <= (bit_cnt != '0);
                  bit_cnt       <= '0;
               end else if (clk_rise) begin
                  shift_word <= shift_in;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     wr_req  <= 1'b1;
                     wr_word <= shift_in;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_STEP;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .wr_en   (wr_req),
      .wr_data (wr_word),
      .rd_en   (data_ready_in),
      .rd_data (data_out),
      .valid   (data_valid_out),
      .fill    (fill_out),
      .wr_drop (wr_drop)
   );

   // Clear wins over a same-cycle overflow.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         overflow_out <= 1'b0;
      end else if (clear_in) begin
         overflow_out <= 1'b0;
      end else if (wr_drop) begin
         overflow_out <= 1'b1;
      end
   end

`ifdef SPI_RX_WORD_COUNT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         word_count_out <= '0;
      end else if (wr_req && !wr_drop) begin
         word_count_out <= word_count_out + 16'd1;
      end
   end
`else
   // This build carries no accepted-word counter.
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed and randomised bench for spi_frame_receiver: default 8b/4-lane instance plus a 16b/2-lane instance.
`timescale 1ns/1ps
module tb_spi_frame_receiver;

   localparam int SYNC = 2;
   localparam int HALF = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] a_data;
   logic       a_sclk, a_cs, a_ready, a_clear;
   logic [7:0] a_out;
   logic       a_valid, a_fe, a_tr, a_ovf;
   logic [3:0] a_fill;

   logic [1:0]  b_data;
   logic        b_sclk, b_cs, b_ready, b_clear;
   logic [15:0] b_out;
   logic        b_valid, b_fe, b_tr, b_ovf;
   logic [3:0]  b_fill;
`ifdef SPI_RX_WORD_COUNT_EN
   logic [15:0] a_wc, b_wc;
`endif

   spi_frame_receiver u_a (
      .clk_in(clk), .rst_n_in(rst_n), .chip_data_in(a_data), .chip_clk_in(a_sclk),
      .chip_sel_in(a_cs), .data_out(a_out), .data_valid_out(a_valid), .data_ready_in(a_ready),
      .frame_end_out(a_fe), .trunc_out(a_tr), .overflow_out(a_ovf), .clear_in(a_clear),
      .fill_out(a_fill)
`ifdef SPI_RX_WORD_COUNT_EN
      , .word_count_out(a_wc)
`endif
   );

   spi_frame_receiver #(.DATA_WIDTH(16), .LINES(2)) u_b (
      .clk_in(clk), .rst_n_in(rst_n), .chip_data_in(b_data), .chip_clk_in(b_sclk),
      .chip_sel_in(b_cs), .data_out(b_out), .data_valid_out(b_valid), .data_ready_in(b_ready),
      .frame_end_out(b_fe), .trunc_out(b_tr), .overflow_out(b_ovf), .clear_in(b_clear),
      .fill_out(b_fill)
`ifdef SPI_RX_WORD_COUNT_EN
      , .word_count_out(b_wc)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   int a_fe_cnt = 0, a_tr_cnt = 0, b_fe_cnt = 0, b_tr_cnt = 0;

   always @(posedge clk) begin
      a_fe_cnt <= a_fe_cnt + ((a_fe === 1'b1) ? 1 : 0);
      a_tr_cnt <= a_tr_cnt + ((a_tr === 1'b1) ? 1 : 0);
      b_fe_cnt <= b_fe_cnt + ((b_fe === 1'b1) ? 1 : 0);
      b_tr_cnt <= b_tr_cnt + ((b_tr === 1'b1) ? 1 : 0);
   end

   // Reference model: expected FIFO contents as a bounded queue plus a sticky overflow flag.
   logic [7:0] q[$];
   bit         ovf_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_push(input logic [7:0] w);
      if (q.size() < 8) q.push_back(w);
      else ovf_m = 1'b1;
   endtask

   task automatic a_beat(input logic [3:0] v);
      a_data = v;
      wait_cyc(HALF);
      a_sclk = 1'b1;
      wait_cyc(HALF);
      a_sclk = 1'b0;
   endtask

   task automatic a_byte(input logic [7:0] w);
      a_beat(w[7:4]);
      a_beat(w[3:0]);
   endtask

   task automatic a_cs_low();
      a_cs = 1'b0;
      wait_cyc(HALF);
   endtask

   task automatic a_cs_high();
      wait_cyc(HALF);
      a_cs = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic a_drain();
      while (q.size() > 0) begin
         check("drain_valid", a_valid, 1);
         check("drain_data", a_out, q[0]);
         a_ready = 1'b1;
         wait_cyc(1);
         a_ready = 1'b0;
         void'(q.pop_front());
      end
      check("drain_empty", a_valid, 0);
      check("drain_fill", a_fill, 0);
   endtask

   task automatic a_clear_ovf();
      a_clear = 1'b1;
      wait_cyc(1);
      a_clear = 1'b0;
      wait_cyc(1);
      ovf_m = 1'b0;
      check("clear_ovf", a_ovf, 0);
   endtask

   task automatic b_beat(input logic [1:0] v);
      b_data = v;
      wait_cyc(HALF);
      b_sclk = 1'b1;
      wait_cyc(HALF);
      b_sclk = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          fe0, tr0, lat, nw;
      bit          part;
      logic [7:0]  w;
      logic [15:0] bw;

      rst_n = 1'b0;
      a_data = '0; a_sclk = 1'b0; a_cs = 1'b1; a_ready = 1'b0; a_clear = 1'b0;
      b_data = '0; b_sclk = 1'b0; b_cs = 1'b1; b_ready = 1'b0; b_clear = 1'b0;
      ovf_m = 1'b0;
      wait_cyc(3);
      check("rst_data", a_out, 0);
      check("rst_valid", a_valid, 0);
      check("rst_frame_end", a_fe, 0);
      check("rst_trunc", a_tr, 0);
      check("rst_overflow", a_ovf, 0);
      check("rst_fill", a_fill, 0);
      rst_n = 1'b1;
      wait_cyc(2 * HALF);

      // 0xA5 as two nibble beats, with first-word latency measured from the completing pin edge.
      fe0 = a_fe_cnt; tr0 = a_tr_cnt;
      a_cs_low();
      a_beat(4'hA);
      a_data = 4'h5;
      wait_cyc(HALF);
      a_sclk = 1'b1;
      lat = 0;
      while (a_valid !== 1'b1 && lat < 20) begin
         wait_cyc(1);
         lat++;
      end
      check("latency", lat, SYNC + 3);
      wait_cyc(HALF);
      a_sclk = 1'b0;
      a_cs_high();
      check("a5_data", a_out, 8'hA5);
      check("a5_valid", a_valid, 1);
      check("a5_fill", a_fill, 1);
      check("a5_frame_end", a_fe_cnt - fe0, 1);
      check("a5_trunc", a_tr_cnt - tr0, 0);
      q.push_back(8'hA5);
      a_drain();

      // Half a word, then cs high: truncation, nothing written.
      fe0 = a_fe_cnt; tr0 = a_tr_cnt;
      a_cs_low();
      a_beat(4'h7);
      a_cs_high();
      check("trunc_pulse", a_tr_cnt - tr0, 1);
      check("trunc_frame_end", a_fe_cnt - fe0, 1);
      check("trunc_fill", a_fill, 0);
      check("trunc_valid", a_valid, 0);

      // Nine bytes into an eight-deep FIFO with no consumer.
      a_cs_low();
      for (int i = 1; i <= 9; i++) begin
         a_byte(8'(i));
         model_push(8'(i));
      end
      a_cs_high();
      check("ovf_fill", a_fill, 8);
      check("ovf_set", a_ovf, ovf_m);
      a_drain();
      check("ovf_sticky", a_ovf, 1);
      a_clear_ovf();

      // Pop lands on the same edge as the ninth write: slot freed, no overflow.
      a_cs_low();
      for (int i = 8'h11; i <= 8'h18; i++) begin
         a_byte(8'(i));
         q.push_back(8'(i));
      end
      a_beat(4'h1);
      a_data = 4'h9;
      wait_cyc(HALF);
      a_sclk = 1'b1;
      wait_cyc(SYNC + 2);
      check("simul_head", a_out, 8'h11);
      a_ready = 1'b1;
      wait_cyc(1);
      a_ready = 1'b0;
      void'(q.pop_front());
      q.push_back(8'h19);
      wait_cyc(3);
      a_sclk = 1'b0;
      a_cs_high();
      check("simul_fill", a_fill, 8);
      check("simul_ovf", a_ovf, 0);
      a_drain();

      // Reset mid-frame with a word already buffered; the rest of that frame is ignored.
      a_cs_low();
      a_byte(8'h5A);
      a_beat(4'hF);
      wait_cyc(HALF);
      rst_n = 1'b0;
      wait_cyc(2);
      check("midrst_fill", a_fill, 0);
      check("midrst_valid", a_valid, 0);
      check("midrst_data", a_out, 0);
      rst_n = 1'b1;
      q.delete();
      ovf_m = 1'b0;
      a_beat(4'h0);
      a_cs_high();
      a_cs_low();
      a_byte(8'h3C);
      a_cs_high();
      check("post_rst_fill", a_fill, 1);
      check("post_rst_data", a_out, 8'h3C);
`ifdef SPI_RX_WORD_COUNT_EN
      check("word_count", a_wc, 1);
`endif
      q.push_back(8'h3C);
      a_drain();

      // Random frames against the queue model; drains are occasional so overflow can build up.
      for (int f = 0; f < 8; f++) begin
         nw = $urandom_range(1, 4);
         part = 1'($urandom_range(0, 1));
         fe0 = a_fe_cnt; tr0 = a_tr_cnt;
         a_cs_low();
         for (int k = 0; k < nw; k++) begin
            w = 8'($urandom);
            a_byte(w);
            model_push(w);
         end
         if (part) a_beat(4'($urandom));
         a_cs_high();
         check("rnd_frame_end", a_fe_cnt - fe0, 1);
         check("rnd_trunc", a_tr_cnt - tr0, part);
         check("rnd_fill", a_fill, q.size());
         check("rnd_ovf", a_ovf, ovf_m);
         if (ovf_m || $urandom_range(0, 2) == 0 || f == 7) begin
            a_drain();
            a_clear_ovf();
         end
      end

      // Wide instance: 16-bit words over two lanes.
      bw = 16'hE4E4;
      fe0 = b_fe_cnt; tr0 = b_tr_cnt;
      b_cs = 1'b0;
      wait_cyc(HALF);
      for (int k = 0; k < 8; k++) b_beat(bw[15 - 2 * k -: 2]);
      wait_cyc(HALF);
      b_cs = 1'b1;
      wait_cyc(2 * HALF);
      check("b_data", b_out, 16'hE4E4);
      check("b_valid", b_valid, 1);
      check("b_fill", b_fill, 1);
      check("b_frame_end", b_fe_cnt - fe0, 1);
      check("b_trunc0", b_tr_cnt - tr0, 0);
      b_ready = 1'b1;
      wait_cyc(1);
      b_ready = 1'b0;
      check("b_popped", b_valid, 0);

      tr0 = b_tr_cnt;
      b_cs = 1'b0;
      wait_cyc(HALF);
      for (int k = 0; k < 3; k++) b_beat(2'($urandom));
      wait_cyc(HALF);
      b_cs = 1'b1;
      wait_cyc(2 * HALF);
      check("b_trunc", b_tr_cnt - tr0, 1);
      check("b_trunc_fill", b_fill, 0);
      check("b_ovf", b_ovf, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
